// File: rtl/seq_multiplier.sv
// Sequential 16x16 unsigned shift-and-add multiplier: one multiplier bit per clock,
// registered 32-bit product and a one-cycle done pulse after 16 iterations.
module seq_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] res,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] res_q, res_d;
  logic        done_q, done_d;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    res_d    = res_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          mcand_d  = {16'b0, A};
          mplier_d = B;
          acc_d    = '0;
          count_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        // The 16th iteration's sum goes straight into res so it is valid with done.
        if (count_q == 5'd15) begin
          state_d = DONE;
          res_d   = acc_d;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign res  = res_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: expected products and done cycles are queued
// when start is driven and compared whenever the DUT pulses done.
module tb_seq_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] res;
  logic        done;

  typedef struct {
    logic [31:0] prod;
    int          doneCycle;
  } expect_t;

  expect_t sbQ[$];
  int      cycleCount;
  int      checks;
  int      errors;

  seq_multiplier dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .res   (res),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected,
               cycleCount);
    end
  endtask

  // Drive a one-cycle start; the accepted edge is the next posedge, done is due 16 later.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    expect_t e;
    @(posedge clk);
    #1;
    A     = a;
    B     = b;
    start = 1'b1;
    e.prod      = {16'b0, a} * {16'b0, b};
    e.doneCycle = cycleCount + 17;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 60 && sbQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain", sbQ.size(), 0);
  endtask

  // Scoreboard monitor, sampling on the falling edge away from register updates.
  always @(negedge clk) begin
    expect_t e;
    if (!reset && done) begin
      if (sbQ.size() == 0) begin
        checkOutput("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("res", res, e.prod);
        checkOutput("done_cycle", cycleCount, e.doneCycle);
      end
    end
  end

  initial begin
    expect_t e;
    int      startCycle;
    logic [15:0] ra, rb;

    checks     = 0;
    errors     = 0;
    cycleCount = 0;
    reset      = 1'b1;
    start      = 1'b0;
    A          = '0;
    B          = '0;

    #3;
    checkOutput("reset_res", res, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Primary vector and hold of the result.
    applyStimulus(16'h0181, 16'hFFFF);
    waitDone();
    repeat (100) @(posedge clk);
    #1;
    checkOutput("res_hold", res, 32'h0180FE7F);

    // Boundaries.
    applyStimulus(16'hFFFF, 16'hFFFF);
    waitDone();
    checkOutput("max_const", res, 32'hFFFE0001);
    applyStimulus(16'd0, 16'd13);
    waitDone();
    applyStimulus(16'd5, 16'd0);
    waitDone();
    applyStimulus(16'd1, 16'd1);
    waitDone();

    // Operand changes and a start pulse during RUN must be ignored.
    applyStimulus(16'd1234, 16'd567);
    repeat (3) @(posedge clk);
    #1;
    A     = 16'd9999;
    B     = 16'd4321;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone();
    repeat (5) @(posedge clk);

    // Back-to-back with start held high: second operands picked up at the DONE edge.
    @(posedge clk);
    #1;
    A          = 16'd7;
    B          = 16'd6;
    start      = 1'b1;
    startCycle = cycleCount + 1;
    e.prod      = 32'd42;
    e.doneCycle = startCycle + 16;
    sbQ.push_back(e);
    e.prod      = 32'd150;
    e.doneCycle = startCycle + 17 + 16;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    A = 16'd10;
    B = 16'd15;
    while (cycleCount < startCycle + 17) @(posedge clk);
    #1;
    start = 1'b0;
    waitDone();

    // Asynchronous reset mid-RUN, then recovery.
    applyStimulus(16'd300, 16'd200);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midrun_reset_res", res, 32'd0);
    checkOutput("midrun_reset_done", {31'b0, done}, 32'd0);
    sbQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    checkOutput("res_after_reset", res, 32'd0);
    applyStimulus(16'd300, 16'd200);
    waitDone();

    // Random operands against the reference product.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      applyStimulus(ra, rb);
      waitDone();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
